ads_conv_ctrl: RTL
==================

// Module: ads_conv_ctrl
// PURPOSE
//  Conversion/readout controller for the external ADS converter, clocked by CLK_ADS
//  and reset by CLK_RST from the clock-generation stage directly upstream.
//  Waits a power-up holdoff, asserts START, and on each DRDY_N falling edge reads one
//  DATA_W-bit sample over SPI (mode 1, MSB first). Presents each sample as a parallel
//  word with a one-cycle valid strobe to the downstream capture logic.
// PARAMETERS
//  DATA_W    24    sample width in bits (8..32)
//  SCLK_DIV  4     SCLK half-period in CLK_ADS cycles (>=2)
//  HOLDOFF   1024  CLK_ADS cycles after reset release before START may assert (>=1)
// PORTS
//  CLK_ADS     in   1       converter clock; all logic on its rising edge
//  CLK_RST     in   1       reset, synchronous, active-high
//  EN          in   1       run enable; level
//  ADS_DRDY_N  in   1       data-ready from ADS, asynchronous, active-low
//  ADS_DOUT    in   1       serial data from ADS
//  ADS_START   out  1       conversion start to ADS
//  ADS_CS_N    out  1       chip select, active-low
//  ADS_SCLK    out  1       serial clock, idle low
//  DATA        out  DATA_W  last complete sample
//  DATA_VLD    out  1       one-cycle strobe, DATA new this cycle
//  BUSY        out  1       high in CS_SETUP/SHIFT/DONE
//  OVR         out  1       sticky overrun flag, cleared by reset or EN low
// BEHAVIOUR
//  Reset values: ADS_START=0, ADS_CS_N=1, ADS_SCLK=0, DATA=0, DATA_VLD=0, BUSY=0, OVR=0;
//   FSM=HOLD, holdoff counter=0, DRDY_N synchroniser flops preset to 1.
//  ADS_DRDY_N: 2-FF synchroniser plus 1 history flop; fall = prev 1 and sync 0.
//  HOLD: count HOLDOFF cycles, then -> IDLE. EN ignored during HOLD.
//  IDLE: ADS_START=0. EN=1 -> WAIT (ADS_START=1 registered, same cycle as state change).
//  WAIT: EN=0 -> IDLE, START=0, OVR cleared. fall -> CS_SETUP, ADS_CS_N=0.
//  CS_SETUP: SCLK_DIV cycles, SCLK low -> SHIFT.
//  SHIFT: per bit 2*SCLK_DIV cycles: SCLK high SCLK_DIV cycles, then low SCLK_DIV.
//   ADS_DOUT sampled into shift reg (MSB first) on the cycle SCLK is driven high->low.
//   Exactly DATA_W SCLK pulses; after last low phase -> DONE.
//  DONE: 1 cycle; ADS_CS_N=1, DATA<=shift reg, DATA_VLD=1; -> WAIT if EN else IDLE.
//  Latency: sync fall -> ADS_CS_N low 1 cycle; fall -> DATA_VLD =
//   1+SCLK_DIV+2*SCLK_DIV*DATA_W+1 cycles.
//  EN falling during CS_SETUP/SHIFT: frame completes and is delivered, then IDLE.
//  fall while BUSY: OVR<=1 (sticky), event otherwise dropped; current frame unaffected.
//  fall in same cycle as DONE: treated as overrun (dropped, OVR set).
//  CLK_RST mid-frame: all outputs take reset values next edge; no DATA_VLD; HOLD
//   restarts from 0.
//  DATA holds its value between strobes; never partially updated.
// TESTING
//  1 Reset, EN=1, DRDY_N=1 -> START stays 0 for HOLDOFF cycles, rises HOLDOFF+1 after.
//  2 DRDY_N fall, DOUT model shifts 24'hA5C3F0 -> 24 SCLK pulses, period 8 cycles,
//    DATA=24'hA5C3F0, DATA_VLD one cycle at 1+4+192+1=198 cycles after sync fall.
//  3 EN low at bit 10 of frame -> frame completes, DATA_VLD=1, then START=0, CS_N=1.
//  4 Second DRDY_N fall at bit 5 -> OVR=1, DATA still equals driven pattern;
//    EN low -> OVR=0.
//  5 CLK_RST pulse at bit 12 -> CS_N=1, SCLK=0 next cycle, no DATA_VLD, START=0.
//  6 Back-to-back samples 24'h000001, 24'hFFFFFF -> two strobes with exact values.

Source files
------------

// File: rtl/ads_conv_ctrl.sv
// Conversion/readout controller for an ADS-style converter: power-up holdoff, START control,
// DRDY_N edge detection and SPI mode-1 readout of one DATA_W-bit sample per conversion.
`timescale 1ns/1ps
module ads_conv_ctrl #(
  parameter int DATA_W   = 24,
  parameter int SCLK_DIV = 4,
  parameter int HOLDOFF  = 1024
) (
  input  logic              CLK_ADS,
  input  logic              CLK_RST,
  input  logic              EN,
  input  logic              ADS_DRDY_N,
  input  logic              ADS_DOUT,
  output logic              ADS_START,
  output logic              ADS_CS_N,
  output logic              ADS_SCLK,
  output logic [DATA_W-1:0] DATA,
  output logic              DATA_VLD,
  output logic              BUSY,
  output logic              OVR
);

  localparam int HOLD_W = $clog2(HOLDOFF + 1);
  localparam int DIV_W  = $clog2(SCLK_DIV);
  localparam int BIT_W  = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {
    S_HOLD, S_IDLE, S_WAIT, S_CS_SETUP, S_SHIFT, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                sclk_q, sclk_d;
  logic                start_q, start_d;
  logic                cs_n_q, cs_n_d;
  logic                vld_q, vld_d;
  logic                busy_q, busy_d;
  logic                ovr_q, ovr_d;
  logic                drdy_s1_q, drdy_s2_q, drdy_prev_q;
  logic                drdy_fall;
  logic                busy_now;

  assign drdy_fall = drdy_prev_q & ~drdy_s2_q;
  assign busy_now  = (state_q == S_CS_SETUP) || (state_q == S_SHIFT) || (state_q == S_DONE);

  always_ff @(posedge CLK_ADS) begin
    if (CLK_RST) begin
      state_q     <= S_HOLD;
      hold_cnt_q  <= '0;
      div_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      sclk_q      <= 1'b0;
      start_q     <= 1'b0;
      cs_n_q      <= 1'b1;
      vld_q       <= 1'b0;
      busy_q      <= 1'b0;
      ovr_q       <= 1'b0;
      drdy_s1_q   <= 1'b1;
      drdy_s2_q   <= 1'b1;
      drdy_prev_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      div_cnt_q   <= div_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      sclk_q      <= sclk_d;
      start_q     <= start_d;
      cs_n_q      <= cs_n_d;
      vld_q       <= vld_d;
      busy_q      <= busy_d;
      ovr_q       <= ovr_d;
      drdy_s1_q   <= ADS_DRDY_N;
      drdy_s2_q   <= drdy_s1_q;
      drdy_prev_q <= drdy_s2_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    div_cnt_d  = div_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    data_d     = data_q;
    sclk_d     = sclk_q;
    ovr_d      = ovr_q;

    case (state_q)
      S_HOLD: begin
        if (hold_cnt_q == HOLD_W'(HOLDOFF - 1)) state_d = S_IDLE;
        else hold_cnt_d = hold_cnt_q + 1'b1;
      end
      S_IDLE: begin
        if (EN) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!EN) begin
          state_d = S_IDLE;
        end else if (drdy_fall) begin
          state_d   = S_CS_SETUP;
          div_cnt_d = '0;
        end
      end
      S_CS_SETUP: begin
        if (div_cnt_q == DIV_W'(SCLK_DIV - 1)) begin
          state_d   = S_SHIFT;
          div_cnt_d = '0;
          bit_cnt_d = '0;
          sclk_d    = 1'b1;
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      S_SHIFT: begin
        // DOUT is captured as SCLK falls; the slave launched it on the preceding rise.
        if (div_cnt_q == DIV_W'(SCLK_DIV - 1)) begin
          div_cnt_d = '0;
          if (sclk_q) begin
            sclk_d    = 1'b0;
            shift_d   = {shift_q[DATA_W-2:0], ADS_DOUT};
            bit_cnt_d = bit_cnt_q + 1'b1;
          end else if (bit_cnt_q == BIT_W'(DATA_W)) begin
            state_d = S_DONE;
          end else begin
            sclk_d = 1'b1;
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        data_d  = shift_q;
        state_d = EN ? S_WAIT : S_IDLE;
      end
      default: state_d = S_HOLD;
    endcase

    // An edge arriving mid-frame (including the DONE cycle) is lost; flag it.
    if (drdy_fall && busy_now) ovr_d = 1'b1;
    else if (!EN && !busy_now) ovr_d = 1'b0;
  end

  assign start_d = (state_d == S_WAIT) || (state_d == S_CS_SETUP) ||
                   (state_d == S_SHIFT) || (state_d == S_DONE);
  assign cs_n_d  = !((state_d == S_CS_SETUP) || (state_d == S_SHIFT));
  assign busy_d  = (state_d == S_CS_SETUP) || (state_d == S_SHIFT) || (state_d == S_DONE);
  assign vld_d   = (state_q == S_DONE);

  assign ADS_START = start_q;
  assign ADS_CS_N  = cs_n_q;
  assign ADS_SCLK  = sclk_q;
  assign DATA      = data_q;
  assign DATA_VLD  = vld_q;
  assign BUSY      = busy_q;
  assign OVR       = ovr_q;

endmodule
